serial_parity_checker: RTL

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

---
 rtl/serial_parity_checker_pkg.sv | 26 ++
 rtl/serial_parity_checker_if.sv | 42 ++++
 rtl/serial_parity_checker_d_ff.sv | 25 ++
 rtl/serial_parity_checker.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker: FSM encoding,
// default frame geometry and the parity verdict helper.
package serial_parity_checker_pkg;

  // Receiver FSM encoding; values are fixed so debug probes read stably.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10
  } state_e;

  // Default number of data bits per frame (legal range 2..32).
  localparam int DEF_DATA_W = 8;

  // Default parity sense: 1 = odd parity, 0 = even parity.
  localparam int DEF_ODD = 1;

  // Returns 1 when the accumulated data parity combined with the received
  // parity bit does not match the selected parity sense.
  function automatic logic parity_err(input logic acc,
                                      input logic pbit,
                                      input logic odd);
    return ((acc ^ pbit) != odd);
  endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial frame bus between a bit source and the parity checker.
//
// Handshake: i_x is meaningful only in cycles where i_valid=1; each such
// cycle consumes exactly one bit on the rising clock edge (the checker is
// always ready). o_valid is a one-cycle pulse; o_data and o_perr describe
// the frame marked by that pulse and hold until the next one. o_state is a
// debug view of the receiver FSM.
interface serial_parity_checker_if #(
  parameter int DATA_W = serial_parity_checker_pkg::DEF_DATA_W
) ();

  logic                             i_x;
  logic                             i_valid;
  logic [DATA_W-1:0]                o_data;
  logic                             o_valid;
  logic                             o_perr;
  logic                             o_busy;
  serial_parity_checker_pkg::state_e o_state;

  // Bit source side.
  modport master (
    output i_x,
    output i_valid,
    input  o_data,
    input  o_valid,
    input  o_perr,
    input  o_busy,
    input  o_state
  );

  // Checker side.
  modport slave (
    input  i_x,
    input  i_valid,
    output o_data,
    output o_valid,
    output o_perr,
    output o_busy,
    output o_state
  );

endinterface

// File: rtl/serial_parity_checker_d_ff.sv
// Plain W-bit D flip-flop with synchronous active-high reset to zero.
// Any hold/clear/update behaviour is decided by the logic feeding i_d.
module d_ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] q_q;

  // Capture i_d every edge; reset clears to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q <= '0;
    end else begin
      q_q <= i_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: receives DATA_W data bits LSB first followed by
// one parity bit, then reports the data word and a parity-error flag with
// a one-cycle o_valid pulse. Bits are consumed only when i_valid=1, so
// gaps of any length may appear anywhere inside a frame.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ODD    = DEF_ODD
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  serial_parity_checker_if.slave bus
);

  // Bit counter wide enough to hold DATA_W itself.
  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic              ODD_BIT  = (ODD != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              perr_q,  perr_d;
  logic              par_q,   par_d;
  logic              busy;

  // State register; reset wins over any incoming bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance only on consumed bits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.i_valid && (cnt_q == LAST_IDX)) begin
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (bus.i_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output/datapath logic: every register holds unless a bit is consumed.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    par_d   = par_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          // Frame start: bit 0 lands in the LSB, parity restarts from it.
          cnt_d      = CNT_W'(1);
          shreg_d    = '0;
          shreg_d[0] = bus.i_x;
          par_d      = bus.i_x;
        end
      end
      ST_DATA: begin
        busy = 1'b1;
        if (bus.i_valid) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shreg_d[i] = bus.i_x;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          par_d = par_q ^ bus.i_x;
        end
      end
      ST_PARITY: begin
        busy = 1'b1;
        if (bus.i_valid) begin
          // Parity bit: publish the frame; the next bit starts a new frame.
          valid_d = 1'b1;
          data_d  = shreg_q;
          perr_d  = parity_err(par_q, bus.i_x, ODD_BIT);
          cnt_d   = '0;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
    end
  end

  // Running parity accumulator; clear-on-start and hold are in par_d.
  d_ff #(
    .W (1)
  ) u_par_acc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (par_d),
    .o_q   (par_q)
  );

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_perr  = perr_q;
  assign bus.o_busy  = busy;
  assign bus.o_state = state_q;

endmodule
